// File: rtl/rgb_frame_fetcher.sv
// Reads a packed RGB frame (3 words per pixel pair) from SRAM and streams it
// out one pixel per handshake, with sof/eol markers and credit-based flow control.
module rgb_frame_fetcher #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter int          FRAME_W    = 320,
    parameter int          FRAME_H    = 240,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_R,
    output logic [7:0]  pix_G,
    output logic [7:0]  pix_B,
    output logic        pix_sof,
    output logic        pix_eol
);
    localparam int NPAIRS = FRAME_W * FRAME_H / 2;
    localparam int PW     = $clog2(NPAIRS);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int XW     = $clog2(FRAME_W);
    localparam int YW     = $clog2(FRAME_H);

    typedef enum logic [2:0] {IDLE, F0, F1, F2, WAIT_CREDIT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [17:0]       addr_q, sram_addr_q;
    logic [PW-1:0]     pair_q;
    logic [1:0]        tag_vld_q;
    logic [1:0][1:0]   tag_idx_q;
    logic [7:0]        r0_q, g0_q, r1_q;
    logic [CW-1:0]     pend_q, pend_d;
    logic [23:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     mem_cnt_q;
    logic              hv_q;
    logic [23:0]       head_q;
    logic [XW-1:0]     col_q;
    logic [YW-1:0]     row_q;

    logic              issue, start_acc, credit_ok, drained, last_pair;
    logic [1:0]        widx;
    logic              push, pop, load;
    logic [23:0]       push_px;
    logic [CW-1:0]     fifo_cnt;
    logic [CW+1:0]     resv;

    // Occupancy counts the head register too, so credit covers every stored pixel.
    assign fifo_cnt  = mem_cnt_q + CW'(hv_q);
    assign resv      = (CW+2)'(fifo_cnt) + (CW+2)'(pend_q);
    assign credit_ok = (resv + (CW+2)'(2)) <= (CW+2)'(FIFO_DEPTH);
    assign last_pair = (pair_q == PW'(NPAIRS - 1));
    assign start_acc = (state_q == IDLE) && Start;
    assign pop       = hv_q && pix_ready;
    assign load      = (mem_cnt_q != '0) && (!hv_q || pop);
    assign drained   = (tag_vld_q == 2'b00) && (pend_q == '0) && (fifo_cnt == '0) && !pop;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        widx    = 2'd0;
        done_d  = 1'b0;
        case (state_q)
            IDLE:        if (Start) state_d = F0;
            F0: begin
                if (credit_ok) begin
                    issue   = 1'b1;
                    state_d = F1;
                end else begin
                    state_d = WAIT_CREDIT;
                end
            end
            F1: begin
                issue   = 1'b1;
                widx    = 2'd1;
                state_d = F2;
            end
            F2: begin
                issue   = 1'b1;
                widx    = 2'd2;
                state_d = last_pair ? DRAIN : F0;
            end
            WAIT_CREDIT: if (credit_ok) state_d = F0;
            DRAIN: begin
                if (drained) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default:     state_d = IDLE;
        endcase
    end

    // Word 1 completes pixel 0; word 2 carries all of pixel 1's green and blue.
    always_comb begin
        push    = 1'b0;
        push_px = {r1_q, SRAM_read_data};
        if (tag_vld_q[1]) begin
            if (tag_idx_q[1] == 2'd1) begin
                push    = 1'b1;
                push_px = {r0_q, g0_q, SRAM_read_data[15:8]};
            end else if (tag_idx_q[1] == 2'd2) begin
                push    = 1'b1;
            end
        end
        pend_d = pend_q + ((issue && widx == 2'd0) ? CW'(2) : CW'(0)) - CW'(push);
    end

    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q] <= push_px;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            addr_q      <= RGB_BASE;
            sram_addr_q <= RGB_BASE;
            pair_q      <= '0;
            tag_vld_q   <= '0;
            tag_idx_q   <= '0;
            r0_q        <= '0;
            g0_q        <= '0;
            r1_q        <= '0;
            pend_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            hv_q        <= 1'b0;
            head_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_acc) begin
                addr_q      <= RGB_BASE;
                sram_addr_q <= RGB_BASE;
                pair_q      <= '0;
            end else if (issue) begin
                sram_addr_q <= addr_q;
                addr_q      <= addr_q + 18'd1;
                if (widx == 2'd2) pair_q <= pair_q + PW'(1);
            end
            tag_vld_q <= {tag_vld_q[0], issue};
            tag_idx_q <= {tag_idx_q[0], widx};
            if (tag_vld_q[1]) begin
                if (tag_idx_q[1] == 2'd0) begin
                    r0_q <= SRAM_read_data[15:8];
                    g0_q <= SRAM_read_data[7:0];
                end else if (tag_idx_q[1] == 2'd1) begin
                    r1_q <= SRAM_read_data[7:0];
                end
            end
            pend_q <= pend_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (load) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                head_q   <= mem_q[rd_ptr_q];
                hv_q     <= 1'b1;
            end else if (pop) begin
                hv_q <= 1'b0;
            end
            mem_cnt_q <= mem_cnt_q + CW'(push) - CW'(load);
            if (start_acc) begin
                col_q <= '0;
                row_q <= '0;
            end else if (pop) begin
                if (col_q == XW'(FRAME_W - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == YW'(FRAME_H - 1)) ? '0 : row_q + YW'(1);
                end else begin
                    col_q <= col_q + XW'(1);
                end
            end
        end
    end

    assign Busy            = (state_q != IDLE);
    assign Done            = done_q;
    assign SRAM_address    = sram_addr_q;
    assign SRAM_write_data = 16'd0;
    assign SRAM_we_n       = 1'b1;
    assign pix_valid       = hv_q;
    assign pix_R           = head_q[23:16];
    assign pix_G           = head_q[15:8];
    assign pix_B           = head_q[7:0];
    assign pix_sof         = hv_q && (col_q == '0) && (row_q == '0);
    assign pix_eol         = hv_q && (col_q == XW'(FRAME_W - 1));
endmodule

// File: tb/tb_rgb_frame_fetcher.sv
// Scoreboard bench for rgb_frame_fetcher: expected pixels are unpacked from the
// SRAM image at Start and compared by a monitor on every handshake.
module tb_rgb_frame_fetcher;
    localparam int W    = 16;
    localparam int H    = 6;
    localparam int D    = 8;
    localparam int NPIX = W * H;
    localparam int NW   = NPIX * 3 / 2;
    localparam logic [17:0] BASE = 18'(262144 - NW);

    logic        Clock = 1'b0, Resetn = 1'b0, Start = 1'b0, pix_ready = 1'b0;
    logic        Busy, Done, SRAM_we_n, pix_valid, pix_sof, pix_eol;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data = 16'd0, SRAM_write_data;
    logic [7:0]  pix_R, pix_G, pix_B;

    bit [15:0]   mem [0:262143];
    logic [25:0] exp_q [$];
    int          errors = 0, checks = 0;
    int          frame_pops = 0, eol_cnt = 0, done_seen = 0;
    bit          rdy_rand = 1'b0;

    rgb_frame_fetcher #(.RGB_BASE(BASE), .FRAME_W(W), .FRAME_H(H), .FIFO_DEPTH(D)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Busy(Busy), .Done(Done),
        .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data),
        .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_R(pix_R), .pix_G(pix_G),
        .pix_B(pix_B), .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    always #5 Clock = ~Clock;

    // Data for the address registered at one edge is on the bus during the next cycle.
    always @(posedge Clock) SRAM_read_data <= mem[SRAM_address];

    always @(posedge Clock) begin
        if (rdy_rand) begin
            #2;
            pix_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] golden(input int p);
        int pair = p / 2;
        logic [15:0] w0, w1, w2;
        logic eol;
        w0  = mem[int'(BASE) + 3 * pair];
        w1  = mem[int'(BASE) + 3 * pair + 1];
        w2  = mem[int'(BASE) + 3 * pair + 2];
        eol = ((p % W) == W - 1);
        if (p % 2 == 0) return {w0[15:8], w0[7:0], w1[15:8], (p == 0), eol};
        else            return {w1[7:0], w2[15:8], w2[7:0], 1'b0, eol};
    endfunction

    always @(negedge Clock) begin
        if (Done) done_seen++;
        if (Resetn && Busy) begin
            int off = int'(SRAM_address) - int'(BASE);
            int outstanding = 2 * (off / 3 + 1) - frame_pops;
            chk("outstanding_le_depth", 32'(outstanding <= D), 32'd1);
        end
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no pixel",
                         {pix_R, pix_G, pix_B, pix_sof, pix_eol});
            end else begin
                chk("pixel", 32'({pix_R, pix_G, pix_B, pix_sof, pix_eol}), 32'(exp_q.pop_front()));
            end
            frame_pops++;
            if (pix_eol) eol_cnt++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic fill_mem(input bit incr);
        for (int i = 0; i < NW; i++)
            mem[int'(BASE) + i] = incr ? 16'(i) : 16'($urandom);
    endtask

    task automatic expect_frame();
        for (int p = 0; p < NPIX; p++) exp_q.push_back(golden(p));
    endtask

    task automatic start_frame();
        frame_pops = 0;
        eol_cnt    = 0;
        Start      = 1'b1;
        tick();
        Start      = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"}, 32'(SRAM_address), 32'(BASE));
        chk({tag, "_we_n"}, 32'(SRAM_we_n), 32'd1);
        chk({tag, "_wdata"}, 32'(SRAM_write_data), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_rgb"}, 32'({pix_R, pix_G, pix_B}), 32'd0);
        chk({tag, "_sof_eol"}, 32'({pix_sof, pix_eol}), 32'd0);
    endtask

    task automatic finish_frame(input string tag, input int d0);
        int n = 0;
        while (done_seen == d0 && n < 3000) begin
            tick();
            n++;
        end
        if (done_seen == d0) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no Done after %0d cycles, required one", tag, n);
        end
        repeat (4) tick();
        chk({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
        chk({tag, "_pops"}, 32'(frame_pops), 32'(NPIX));
        chk({tag, "_eol_count"}, 32'(eol_cnt), 32'(H));
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_low"}, 32'(Busy), 32'd0);
        chk({tag, "_last_addr"}, 32'(SRAM_address), 32'(int'(BASE) + NW - 1));
    endtask

    initial begin
        int d0;
        logic [17:0] a_hold;
        repeat (3) tick();
        check_reset_vals("reset");
        Resetn = 1'b1;
        tick();

        // Directed first pair and start-to-valid latency.
        fill_mem(1'b0);
        mem[int'(BASE)]     = 16'hA1B2;
        mem[int'(BASE) + 1] = 16'hC3D4;
        mem[int'(BASE) + 2] = 16'hE5F6;
        expect_frame();
        pix_ready = 1'b1;
        d0 = done_seen;
        start_frame();
        chk("t1_busy", 32'(Busy), 32'd1);
        repeat (4) tick();
        @(negedge Clock);
        chk("t1_valid_edge4", 32'(pix_valid), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        chk("t1_valid_edge5", 32'(pix_valid), 32'd1);
        chk("t1_px0", 32'({pix_R, pix_G, pix_B, pix_sof}), 32'({24'hA1B2C3, 1'b1}));
        finish_frame("t1", d0);

        // Incrementing pattern, always ready.
        fill_mem(1'b1);
        expect_frame();
        d0 = done_seen;
        start_frame();
        finish_frame("t2", d0);

        // Consumer stalled: issue stops once credit is exhausted.
        fill_mem(1'b0);
        expect_frame();
        pix_ready = 1'b0;
        d0 = done_seen;
        start_frame();
        repeat (150) tick();
        a_hold = SRAM_address;
        repeat (50) tick();
        chk("t3_addr_stalled", 32'(SRAM_address), 32'(a_hold));
        chk("t3_addr_credit", 32'(SRAM_address), 32'(int'(BASE) + 3 * (D / 2) - 1));
        chk("t3_valid", 32'(pix_valid), 32'd1);
        chk("t3_no_pops", 32'(frame_pops), 32'd0);
        pix_ready = 1'b1;
        finish_frame("t3", d0);

        // Random backpressure with a stray Start mid-frame.
        fill_mem(1'b0);
        expect_frame();
        rdy_rand = 1'b1;
        d0 = done_seen;
        start_frame();
        repeat (30) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t4_busy_after_restart", 32'(Busy), 32'd1);
        finish_frame("t4", d0);
        rdy_rand = 1'b0;
        tick();
        pix_ready = 1'b1;

        // Reset mid-frame, then a fresh frame from the base.
        fill_mem(1'b0);
        expect_frame();
        start_frame();
        repeat (40) tick();
        Resetn = 1'b0;
        #1;
        check_reset_vals("t5_reset");
        exp_q.delete();
        repeat (2) tick();
        Resetn = 1'b1;
        tick();
        fill_mem(1'b0);
        expect_frame();
        d0 = done_seen;
        start_frame();
        finish_frame("t5", d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
